// File: rtl/step_ctrl.sv
// Single-step / auto-run clock-enable controller for a processor SoC.
// Debounces a pushbutton, tracks MANUAL/RUN/PAUSE mode and emits one-cycle step pulses.
module step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_DIV        = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        button,
  input  logic        run_mode,
  input  logic [1:0]  rate_sel,
  output logic        step_en,
  output logic        btn_level,
  output logic [1:0]  mode_state,
  output logic [15:0] step_count
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int AD_W = $clog2(AUTO_DIV) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MANUAL = 2'b00,
    RUN    = 2'b01,
    PAUSE  = 2'b10
  } state_t;

  state_t          state;
  logic            btn_s1, btn_s2, mode_s1, mode_s2;
  logic            btn_prev;
  logic            press;
  logic [DB_W-1:0] db_cnt;
  logic [AD_W-1:0] auto_cnt;

  // Terminal count for the auto period; clamped to a 2-cycle period so that
  // step_en can never be high on consecutive cycles at the fastest rate.
  function automatic logic [AD_W-1:0] auto_limit(input logic [1:0] sel);
    logic [AD_W-1:0] per;
    per = AD_W'(AUTO_DIV) >> sel;
    if (per < AD_W'(2)) per = AD_W'(2);
    return per - AD_W'(1);
  endfunction

  assign press      = btn_level & ~btn_prev;
  assign mode_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      mode_s1   <= 1'b0;
      mode_s2   <= 1'b0;
      db_cnt    <= '0;
      btn_level <= 1'b0;
      btn_prev  <= 1'b0;
    end else begin
      btn_s1   <= button;
      btn_s2   <= btn_s1;
      mode_s1  <= run_mode;
      mode_s2  <= mode_s1;
      btn_prev <= btn_level;
      if (btn_s2 == btn_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_level <= ~btn_level;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // A mode change always takes priority over a press in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MANUAL;
      auto_cnt   <= '0;
      step_en    <= 1'b0;
      step_count <= '0;
    end else begin
      step_en <= 1'b0;
      if (step_en) step_count <= step_count + 16'd1;
      case (state)
        MANUAL: begin
          if (mode_s2) begin
            state    <= RUN;
            auto_cnt <= '0;
          end else begin
            step_en <= press;
          end
        end
        RUN: begin
          if (!mode_s2) begin
            state    <= MANUAL;
            auto_cnt <= '0;
          end else if (press) begin
            state <= PAUSE;
          end else if (auto_cnt >= auto_limit(rate_sel)) begin
            step_en  <= 1'b1;
            auto_cnt <= '0;
          end else begin
            auto_cnt <= auto_cnt + 1'b1;
          end
        end
        PAUSE: begin
          if (!mode_s2) begin
            state <= MANUAL;
          end else if (press) begin
            state    <= RUN;
            auto_cnt <= '0;
          end
        end
        default: state <= MANUAL;
      endcase
    end
  end

endmodule

// File: tb/tb_step_ctrl.sv
// Randomized scenario bench for step_ctrl with a small debounce and auto period.
module tb_step_ctrl;
  localparam int DB = 4;
  localparam int AD = 8;

  logic        clk = 1'b0;
  logic        rst, button, run_mode;
  logic [1:0]  rate_sel;
  logic        step_en, btn_level;
  logic [1:0]  mode_state;
  logic [15:0] step_count;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  int model_steps = 0;

  step_ctrl #(.DEBOUNCE_CYCLES(DB), .AUTO_DIV(AD)) dut (
    .clk(clk), .rst(rst), .button(button), .run_mode(run_mode),
    .rate_sel(rate_sel), .step_en(step_en), .btn_level(btn_level),
    .mode_state(mode_state), .step_count(step_count)
  );

  always #5 clk = ~clk;

  // Auto period from the rate rule, never shorter than 2 cycles.
  function automatic int period(input int r);
    int p;
    p = AD >> r;
    return (p < 2) ? 2 : p;
  endfunction

  task automatic tick();
    @(negedge clk);
    if (step_en) pulses++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    pulses = 0;
    model_steps = 0;
  endtask

  task automatic wait_mode(input logic [1:0] m, input int bound, input string tag);
    int w = 0;
    while (mode_state !== m && w < bound) begin tick(); w++; end
    vectors++;
    if (mode_state !== m) begin
      miscompares++;
      $display("FAIL %s: mode_state=%b required %b", tag, mode_state, m);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; button = 1'b0; run_mode = 1'b0; rate_sel = 2'd0;
    repeat (3) tick();
    vectors += 4;
    if (step_en !== 1'b0) begin miscompares++; $display("FAIL reset_step_en: got %b required 0", step_en); end
    if (btn_level !== 1'b0) begin miscompares++; $display("FAIL reset_btn_level: got %b required 0", btn_level); end
    if (mode_state !== 2'b00) begin miscompares++; $display("FAIL reset_mode: got %b required 00", mode_state); end
    if (step_count !== 16'd0) begin miscompares++; $display("FAIL reset_count: got %0d required 0", step_count); end
    rst = 1'b0;
    tick();
    pulses = 0;
  endtask

  task automatic test_manual();
    int rise_at = -1;
    do_reset();
    run_mode = 1'b0;
    button = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (btn_level && rise_at < 0) rise_at = i;
    end
    model_steps = 1;
    tick();
    vectors += 3;
    if (rise_at !== 2 + DB) begin miscompares++; $display("FAIL manual_rise: at %0d required %0d", rise_at, 2 + DB); end
    if (pulses !== model_steps) begin miscompares++; $display("FAIL manual_pulses: got %0d required %0d", pulses, model_steps); end
    if (step_count !== 16'(model_steps)) begin miscompares++; $display("FAIL manual_count: got %0d required %0d", step_count, model_steps); end
    button = 1'b0;
    repeat (12) tick();
    vectors += 2;
    if (pulses !== model_steps) begin miscompares++; $display("FAIL release_pulses: got %0d required %0d", pulses, model_steps); end
    if (btn_level !== 1'b0) begin miscompares++; $display("FAIL release_level: got %b required 0", btn_level); end
  endtask

  task automatic test_bounce();
    logic seen_high = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      button = ((i >> 1) & 1) == 0;
      tick();
      if (btn_level) seen_high = 1'b1;
    end
    button = 1'b0;
    repeat (10) tick();
    vectors += 3;
    if (seen_high !== 1'b0) begin miscompares++; $display("FAIL bounce_level: rose=%b required 0", seen_high); end
    if (pulses !== 0) begin miscompares++; $display("FAIL bounce_pulses: got %0d required 0", pulses); end
    if (step_count !== 16'd0) begin miscompares++; $display("FAIL bounce_count: got %0d required 0", step_count); end
  endtask

  task automatic test_random_presses();
    int lens[6] = '{1, 2, 3, 4, 5, 9};
    int len;
    do_reset();
    run_mode = 1'b0;
    for (int k = 0; k < 8; k++) begin
      len = (k == 0) ? DB - 1 : (k == 1) ? DB : lens[$urandom_range(0, 5)];
      button = 1'b1;
      repeat (len) tick();
      button = 1'b0;
      repeat (10 + $urandom_range(0, 3)) tick();
      if (len >= DB) model_steps++;
      vectors++;
      if (pulses !== model_steps) begin
        miscompares++;
        $display("FAIL press_len%0d: pulses=%0d required %0d", len, pulses, model_steps);
      end
    end
    vectors++;
    if (step_count !== 16'(model_steps)) begin miscompares++; $display("FAIL press_count: got %0d required %0d", step_count, model_steps); end
  endtask

  task automatic test_auto();
    int g;
    int r;
    int base;
    do_reset();
    run_mode = 1'b1; rate_sel = 2'd0;
    wait_mode(2'b01, 6, "auto_enter");
    for (int k = 0; k < 5; k++) begin
      g = 0;
      do begin tick(); g++; end while (!step_en && g < 40);
      vectors++;
      if (g !== period(0)) begin miscompares++; $display("FAIL auto_gap%0d: got %0d required %0d", k, g, period(0)); end
    end
    base = pulses;
    repeat (40) tick();
    vectors++;
    if (pulses - base < 4 || pulses - base > 5) begin
      miscompares++; $display("FAIL auto_window: got %0d pulses required 4..5", pulses - base);
    end
    for (int s = 0; s < 5; s++) begin
      r = (s == 0) ? 2 : $urandom_range(0, 3);
      rate_sel = 2'(r);
      g = 0;
      do begin tick(); g++; end while (!step_en && g < 40);
      vectors++;
      if (!step_en) begin miscompares++; $display("FAIL rate%0d_first: no pulse within %0d cycles", r, g); end
      for (int k = 0; k < 4; k++) begin
        g = 0;
        do begin tick(); g++; end while (!step_en && g < 40);
        vectors++;
        if (g !== period(r)) begin miscompares++; $display("FAIL rate%0d_gap: got %0d required %0d", r, g, period(r)); end
      end
    end
  endtask

  task automatic test_pause();
    int base;
    int g;
    do_reset();
    run_mode = 1'b1; rate_sel = 2'd0;
    wait_mode(2'b01, 6, "pause_enter_run");
    button = 1'b1;
    wait_mode(2'b10, 20, "pause_enter");
    base = pulses;
    repeat (3) tick();
    button = 1'b0;
    repeat (30) tick();
    vectors += 2;
    if (pulses !== base) begin miscompares++; $display("FAIL pause_pulses: got %0d required %0d", pulses - base, 0); end
    if (mode_state !== 2'b10) begin miscompares++; $display("FAIL pause_hold: mode=%b required 10", mode_state); end
    button = 1'b1;
    wait_mode(2'b01, 20, "resume");
    g = 0;
    do begin tick(); g++; end while (!step_en && g < 30);
    vectors++;
    if (g !== period(0)) begin miscompares++; $display("FAIL resume_gap: got %0d required %0d", g, period(0)); end
    button = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_simultaneous();
    int base;
    do_reset();
    run_mode = 1'b1; rate_sel = 2'd0;
    wait_mode(2'b01, 6, "simul_enter_run");
    button = 1'b1;
    repeat (4) tick();
    run_mode = 1'b0;
    repeat (2) tick();
    vectors++;
    if (mode_state !== 2'b01) begin miscompares++; $display("FAIL simul_pre: mode=%b required 01", mode_state); end
    tick();
    vectors += 2;
    if (mode_state !== 2'b00) begin miscompares++; $display("FAIL simul_mode: mode=%b required 00", mode_state); end
    if (step_en !== 1'b0) begin miscompares++; $display("FAIL simul_step: step_en=%b required 0", step_en); end
    base = pulses;
    repeat (10) tick();
    button = 1'b0;
    repeat (10) tick();
    vectors++;
    if (pulses !== base) begin miscompares++; $display("FAIL simul_after: got %0d extra pulses required 0", pulses - base); end
  endtask

  task automatic test_wrap_reset();
    logic [15:0] exp_cnt;
    logic        pending = 1'b0;
    int          n = 0;
    int          g;
    do_reset();
    run_mode = 1'b1; rate_sel = 2'd2;
    wait_mode(2'b01, 6, "wrap_enter_run");
    force dut.step_count = 16'hFFFD;
    tick();
    release dut.step_count;
    exp_cnt = 16'hFFFD;
    for (int t = 0; t < 30 && n < 3; t++) begin
      if (pending) begin
        vectors++;
        if (step_count !== exp_cnt) begin miscompares++; $display("FAIL wrap_count: got %h required %h", step_count, exp_cnt); end
        pending = 1'b0;
      end
      if (step_en) begin exp_cnt = exp_cnt + 16'd1; pending = 1'b1; n++; end
      tick();
    end
    vectors += 2;
    if (step_count !== exp_cnt || exp_cnt !== 16'h0000) begin
      miscompares++; $display("FAIL wrap_final: got %h required 0000", step_count);
    end
    if (n !== 3) begin miscompares++; $display("FAIL wrap_pulses: got %0d required 3", n); end
    rate_sel = 2'd0;
    repeat (3 + $urandom_range(0, 2)) tick();
    rst = 1'b1;
    tick();
    vectors += 4;
    if (step_en !== 1'b0) begin miscompares++; $display("FAIL midrst_step: got %b required 0", step_en); end
    if (btn_level !== 1'b0) begin miscompares++; $display("FAIL midrst_level: got %b required 0", btn_level); end
    if (mode_state !== 2'b00) begin miscompares++; $display("FAIL midrst_mode: got %b required 00", mode_state); end
    if (step_count !== 16'd0) begin miscompares++; $display("FAIL midrst_count: got %h required 0000", step_count); end
    rst = 1'b0;
    wait_mode(2'b01, 4, "post_rst_run");
    g = 0;
    do begin tick(); g++; end while (!step_en && g < 30);
    vectors++;
    if (g !== period(0)) begin miscompares++; $display("FAIL post_rst_gap: got %0d required %0d", g, period(0)); end
  endtask

  task automatic test_held_through_reset();
    run_mode = 1'b0;
    button = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    vectors++;
    if (btn_level !== 1'b0) begin miscompares++; $display("FAIL held_rst_level: got %b required 0", btn_level); end
    rst = 1'b0;
    pulses = 0;
    repeat (14) tick();
    vectors += 2;
    if (pulses !== 1) begin miscompares++; $display("FAIL held_pulses: got %0d required 1", pulses); end
    if (step_count !== 16'd1) begin miscompares++; $display("FAIL held_count: got %0d required 1", step_count); end
    button = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    test_reset();
    test_manual();
    test_bounce();
    test_random_presses();
    test_auto();
    test_pause();
    test_simultaneous();
    test_wrap_reset();
    test_held_through_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
